// File: rtl/router_pkt_tx_if.sv
// Handshake and data signals between the packet source, its requester/payload feeder and the router.
// The master view belongs to router_pkt_tx; the slave view belongs to whatever surrounds it.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic       inject_perr;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       error;
    logic [7:0] d_in;
    logic       pkt_valid;
    logic       req_ready;
    logic       done;
    logic       err_seen;
    logic       req_err;

    modport master (
        input  start, dest, len, inject_perr, pl_data, pl_valid, busy, error,
        output pl_ready, d_in, pkt_valid, req_ready, done, err_seen, req_err
    );
    modport slave (
        output start, dest, len, inject_perr, pl_data, pl_valid, busy, error,
        input  pl_ready, d_in, pkt_valid, req_ready, done, err_seen, req_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers a whole payload, then sends header, payload
// and parity back-to-back (stalling on busy) and records the router's error response.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input logic            clk,
    input logic            resetn,
    router_pkt_tx_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, HDR, PAYLD, PAR, WAIT} state_e;

    localparam logic [5:0] MAX_L = 6'(MAX_LEN);

    state_e     state_q, state_d;
    logic [7:0] mem_q [MAX_LEN];
    logic [7:0] d_in_q, d_in_d, parity_q, parity_d;
    logic       pv_q, pv_d, done_q, done_d, err_q, err_d, rerr_q, rerr_d, perr_q, perr_d;
    logic [1:0] dest_q, dest_d, wcnt_q, wcnt_d;
    logic [5:0] len_q, len_d, wr_q, wr_d, rd_q, rd_d;
    logic       req_ok, pl_hs, consumed;

    assign req_ok   = (bus.len != 6'd0) && (bus.len <= MAX_L) && (bus.dest != 2'd3);
    assign consumed = !bus.busy;
    assign pl_hs    = bus.pl_ready && bus.pl_valid;

    assign bus.pl_ready  = (state_q == LOAD) && (wr_q < len_q);
    assign bus.req_ready = (state_q == IDLE);
    assign bus.d_in      = d_in_q;
    assign bus.pkt_valid = pv_q;
    assign bus.done      = done_q;
    assign bus.err_seen  = err_q;
    assign bus.req_err   = rerr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            d_in_q   <= '0;
            parity_q <= '0;
            pv_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rerr_q   <= 1'b0;
            perr_q   <= 1'b0;
            dest_q   <= '0;
            wcnt_q   <= '0;
            len_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            d_in_q   <= d_in_d;
            parity_q <= parity_d;
            pv_q     <= pv_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rerr_q   <= rerr_d;
            perr_q   <= perr_d;
            dest_q   <= dest_d;
            wcnt_q   <= wcnt_d;
            len_q    <= len_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    // Payload store needs no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (pl_hs) mem_q[wr_q] <= bus.pl_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && req_ok) state_d = LOAD;
            LOAD:    if (wr_q == len_q) state_d = HDR;
            HDR:     if (consumed) state_d = PAYLD;
            PAYLD:   if (consumed && rd_q == len_q) state_d = PAR;
            PAR:     if (consumed) state_d = WAIT;
            WAIT:    if (wcnt_q == 2'd2 && consumed) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        d_in_d   = d_in_q;
        pv_d     = pv_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        rerr_d   = 1'b0;
        err_d    = err_q;
        dest_d   = dest_q;
        len_d    = len_q;
        perr_d   = perr_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (req_ok) begin
                        dest_d   = bus.dest;
                        len_d    = bus.len;
                        perr_d   = bus.inject_perr;
                        err_d    = 1'b0;
                        wr_d     = '0;
                        parity_d = '0;
                    end else begin
                        rerr_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (pl_hs) begin
                    wr_d     = wr_q + 6'd1;
                    parity_d = parity_q ^ bus.pl_data;
                end else if (wr_q == len_q) begin
                    d_in_d   = {len_q, dest_q};
                    pv_d     = 1'b1;
                    parity_d = parity_q ^ {len_q, dest_q};
                end
            end
            HDR: begin
                if (consumed) begin
                    d_in_d = mem_q[0];
                    rd_d   = 6'd1;
                end
            end
            PAYLD: begin
                // pkt_valid drops together with the parity byte, never earlier.
                if (consumed) begin
                    if (rd_q < len_q) begin
                        d_in_d = mem_q[rd_q];
                        rd_d   = rd_q + 6'd1;
                    end else begin
                        d_in_d = parity_q ^ {7'b0, perr_q};
                        pv_d   = 1'b0;
                    end
                end
            end
            PAR: begin
                if (consumed) begin
                    d_in_d = '0;
                    wcnt_d = '0;
                end
            end
            WAIT: begin
                err_d = err_q | bus.error;
                if (wcnt_q != 2'd2) wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd2 && consumed) done_d = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: a packet-level reference model checked every cycle,
// plus hand-computed byte sequences for the canonical packets.
module tb_router_pkt_tx;
    logic clk, resetn;
    router_pkt_tx_if ifc ();

    router_pkt_tx #(.MAX_LEN(63)) dut (.clk(clk), .resetn(resetn), .bus(ifc.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model / compare process ----------------
    typedef enum int {M_IDLE, M_LOAD, M_TX, M_WAIT} mph_e;
    mph_e       ph;
    int         m_len, m_got, m_w, tx_cycles;
    logic [1:0] m_dest;
    logic       m_perr, e_err, e_done, e_rerr, m_nd, m_nr;
    logic [7:0] m_hdr, m_par;
    logic [7:0] m_pay[$];
    logic [8:0] m_exp[$];
    logic [8:0] txlog[$];

    initial begin
        ph = M_IDLE; e_err = 1'b0; e_done = 1'b0; e_rerr = 1'b0; tx_cycles = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_pkt_valid", ifc.pkt_valid, 0);
                chk("rst_d_in", ifc.d_in, 0);
                chk("rst_pl_ready", ifc.pl_ready, 0);
                chk("rst_done", ifc.done, 0);
                chk("rst_req_err", ifc.req_err, 0);
                chk("rst_err_seen", ifc.err_seen, 0);
                ph = M_IDLE; e_err = 1'b0; e_done = 1'b0; e_rerr = 1'b0;
                m_exp.delete(); m_pay.delete();
            end else begin
                chk("req_ready", ifc.req_ready, ph == M_IDLE);
                chk("pl_ready", ifc.pl_ready, ph == M_LOAD && m_got < m_len);
                chk("done", ifc.done, e_done);
                chk("req_err", ifc.req_err, e_rerr);
                chk("err_seen", ifc.err_seen, e_err);
                if (ph != M_TX) begin
                    chk("quiet_pkt_valid", ifc.pkt_valid, 0);
                    chk("quiet_d_in", ifc.d_in, 0);
                end
                m_nd = 1'b0; m_nr = 1'b0;
                case (ph)
                    M_IDLE: if (ifc.start) begin
                        if (ifc.len != 0 && ifc.len <= 63 && ifc.dest != 2'd3) begin
                            ph = M_LOAD; m_len = ifc.len; m_dest = ifc.dest;
                            m_perr = ifc.inject_perr; m_got = 0; m_pay.delete(); e_err = 1'b0;
                        end else m_nr = 1'b1;
                    end
                    M_LOAD: begin
                        if (m_got < m_len) begin
                            if (ifc.pl_valid) begin m_pay.push_back(ifc.pl_data); m_got++; end
                        end else begin
                            // packet image: header, payload, xor of all of them (bit 0 optionally flipped)
                            m_hdr = {m_len[5:0], m_dest};
                            m_par = m_hdr;
                            m_exp.push_back({1'b1, m_hdr});
                            foreach (m_pay[i]) begin
                                m_par = m_par ^ m_pay[i];
                                m_exp.push_back({1'b1, m_pay[i]});
                            end
                            m_par[0] = m_par[0] ^ m_perr;
                            m_exp.push_back({1'b0, m_par});
                            ph = M_TX;
                        end
                    end
                    M_TX: begin
                        tx_cycles++;
                        chk("tx_byte", {ifc.pkt_valid, ifc.d_in}, m_exp[0]);
                        if (!ifc.busy) begin
                            txlog.push_back({ifc.pkt_valid, ifc.d_in});
                            void'(m_exp.pop_front());
                            if (m_exp.size() == 0) begin ph = M_WAIT; m_w = 0; end
                        end
                    end
                    M_WAIT: begin
                        e_err = e_err | ifc.error;
                        m_w++;
                        if (m_w >= 3 && !ifc.busy) begin ph = M_IDLE; m_nd = 1'b1; end
                    end
                    default: ;
                endcase
                e_done = m_nd; e_rerr = m_nr;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pay_src [64];
    logic       rnd_en, es;

    initial forever begin
        @(posedge clk); #1;
        if (rnd_en) begin
            ifc.busy  = ($urandom_range(0, 99) < 30);
            ifc.error = ($urandom_range(0, 99) < 20);
        end
    end

    task automatic do_req(input logic [1:0] d, input logic [5:0] l, input logic pe);
        ifc.start = 1'b1; ifc.dest = d; ifc.len = l; ifc.inject_perr = pe;
        @(posedge clk); #1;
        ifc.start = 1'b0;
    endtask

    task automatic feed(input int l, input int gap);
        int i, t;
        i = 0; t = 0;
        while (i < l && t < 5000) begin
            ifc.pl_valid = ($urandom_range(0, 99) >= gap);
            ifc.pl_data  = pay_src[i];
            @(negedge clk);
            if (ifc.pl_valid && ifc.pl_ready) i++;
            @(posedge clk); #1;
            t++;
        end
        ifc.pl_valid = 1'b0;
        if (i < l) chk("feed_timeout", i, l);
    endtask

    task automatic wait_done(output logic e);
        int t;
        t = 0;
        while (!ifc.done && t < 3000) begin @(negedge clk); t++; end
        if (!ifc.done) chk("done_timeout", 0, 1);
        e = ifc.err_seen;
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input logic [1:0] d, input logic [5:0] l, input logic pe,
                            input int gap, output logic e);
        do_req(d, l, pe);
        feed(l, gap);
        wait_done(e);
    endtask

    task automatic bad_req(input logic [1:0] d, input logic [5:0] l);
        do_req(d, l, 1'b0);
        @(negedge clk);
        chk("bad_req_err_lit", ifc.req_err, 1);
        chk("bad_req_pl_ready_lit", ifc.pl_ready, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_basic(input string nm);
        chk({nm, "_len"}, txlog.size(), 5);
        if (txlog.size() == 5) begin
            chk({nm, "_b0"}, txlog[0], 9'h10D);
            chk({nm, "_b1"}, txlog[1], 9'h111);
            chk({nm, "_b2"}, txlog[2], 9'h122);
            chk({nm, "_b3"}, txlog[3], 9'h133);
            chk({nm, "_b4"}, txlog[4], 9'h00D);
        end
    endtask

    task automatic set_basic_payload();
        pay_src[0] = 8'h11; pay_src[1] = 8'h22; pay_src[2] = 8'h33;
    endtask

    initial begin
        int t;
        n_chk = 0; n_fail = 0; rnd_en = 1'b0;
        ifc.start = 1'b0; ifc.dest = '0; ifc.len = '0; ifc.inject_perr = 1'b0;
        ifc.pl_data = '0; ifc.pl_valid = 1'b0; ifc.busy = 1'b0; ifc.error = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pkt_valid_lit", ifc.pkt_valid, 0);
        chk("reset_done_lit", ifc.done, 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("reset_req_ready_lit", ifc.req_ready, 1);

        // basic packet, no stalls
        set_basic_payload();
        txlog.delete(); tx_cycles = 0;
        send_pkt(2'd1, 6'd3, 1'b0, 0, es);
        check_basic("basic");
        chk("basic_tx_cycles", tx_cycles, 5);
        chk("basic_err_seen", es, 0);

        // same packet, router busy for two cycles while 0x22 is on d_in
        txlog.delete(); tx_cycles = 0;
        fork
            send_pkt(2'd1, 6'd3, 1'b0, 0, es);
            begin
                t = 0;
                while (!(ifc.pkt_valid && ifc.d_in == 8'h22) && t < 200) begin
                    @(posedge clk); #1; t++;
                end
                ifc.busy = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                ifc.busy = 1'b0;
            end
        join
        check_basic("stall");
        chk("stall_tx_cycles", tx_cycles, 7);

        // forced parity error, router reports error in WAIT
        pay_src[0] = 8'hA5;
        txlog.delete(); tx_cycles = 0;
        ifc.error = 1'b1;
        send_pkt(2'd2, 6'd1, 1'b1, 0, es);
        ifc.error = 1'b0;
        chk("perr_len", txlog.size(), 3);
        if (txlog.size() == 3) begin
            chk("perr_hdr", txlog[0], 9'h106);
            chk("perr_pay", txlog[1], 9'h1A5);
            chk("perr_par", txlog[2], 9'h0A2);
        end
        chk("perr_err_seen", es, 1);

        // illegal requests
        tx_cycles = 0;
        bad_req(2'd1, 6'd0);
        bad_req(2'd3, 6'd4);
        chk("bad_req_no_tx", tx_cycles, 0);

        // maximum length with pl_valid gaps
        for (int i = 0; i < 63; i++) pay_src[i] = 8'(i * 7 + 3);
        txlog.delete(); tx_cycles = 0;
        send_pkt(2'd0, 6'd63, 1'b0, 40, es);
        chk("max_len", txlog.size(), 65);
        chk("max_tx_cycles", tx_cycles, 65);
        if (txlog.size() > 0) chk("max_hdr", txlog[0], 9'h1FC);

        // random busy/error around a short packet
        for (int i = 0; i < 5; i++) pay_src[i] = 8'(8'hC0 + i * 5);
        rnd_en = 1'b1;
        send_pkt(2'd2, 6'd5, 1'b0, 20, es);
        rnd_en = 1'b0; ifc.busy = 1'b0; ifc.error = 1'b0;
        @(posedge clk); #1;

        // asynchronous reset while payload is going out
        for (int i = 0; i < 10; i++) pay_src[i] = 8'(8'h40 + i);
        do_req(2'd0, 6'd10, 1'b0);
        feed(10, 0);
        t = 0;
        while (!(ifc.pkt_valid && ifc.d_in == 8'h43) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("rst_mid_reached", ifc.d_in, 8'h43);
        resetn = 1'b0;
        #1;
        chk("rst_mid_pkt_valid_lit", ifc.pkt_valid, 0);
        chk("rst_mid_d_in_lit", ifc.d_in, 0);
        chk("rst_mid_done_lit", ifc.done, 0);
        chk("rst_mid_req_ready_lit", ifc.req_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // clean packet after the reset
        set_basic_payload();
        txlog.delete(); tx_cycles = 0;
        send_pkt(2'd1, 6'd3, 1'b0, 0, es);
        check_basic("post_rst");
        chk("post_rst_tx_cycles", tx_cycles, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
